// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, EX forwarding selects and stall counter.
// Optional macro WB_BYPASS_EN: capture MEM/WB write-back data in place of stale register-file reads.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic [4:0]        id_rd_i,
    input  logic [DATA_W-1:0] id_regdata1_i,
    input  logic [DATA_W-1:0] id_regdata2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              id_mem_read_i,
    input  logic              id_reg_write_i,
    input  logic              flush_i,
    input  logic              ex_mem_reg_write_i,
    input  logic [4:0]        ex_mem_rd_i,
    input  logic              mem_wb_reg_write_i,
    input  logic [4:0]        mem_wb_rd_i,
    input  logic [DATA_W-1:0] mem_wb_wdata_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_regdata1_o,
    output logic [DATA_W-1:0] ex_regdata2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_mem_read_o,
    output logic              ex_reg_write_o,
    output logic [1:0]        forwardA_o,
    output logic [1:0]        forwardB_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_regdata1_q, ex_regdata1_d, ex_regdata2_q, ex_regdata2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic              ex_mem_read_q, ex_mem_read_d, ex_reg_write_q, ex_reg_write_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              hazard, bubble;
    logic [DATA_W-1:0] rdata1, rdata2;

    assign hazard = ex_valid_q && ex_mem_read_q && ex_reg_write_q && ex_rd_q != 5'd0 &&
                    id_valid_i && (ex_rd_q == id_rs_i || ex_rd_q == id_rt_i);
    assign stall_o = hazard && !flush_i;
    assign bubble  = flush_i || hazard;

`ifdef WB_BYPASS_EN
    assign rdata1 = (mem_wb_reg_write_i && mem_wb_rd_i != 5'd0 && mem_wb_rd_i == id_rs_i) ?
                    mem_wb_wdata_i : id_regdata1_i;
    assign rdata2 = (mem_wb_reg_write_i && mem_wb_rd_i != 5'd0 && mem_wb_rd_i == id_rt_i) ?
                    mem_wb_wdata_i : id_regdata2_i;
`else
    logic unused_wdata;
    assign unused_wdata = ^mem_wb_wdata_i;
    assign rdata1 = id_regdata1_i;
    assign rdata2 = id_regdata2_i;
`endif

    // Bubble and flush both zero the whole slot; an invalid ID instruction never writes or loads.
    always_comb begin
        ex_valid_d     = 1'b0;
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_rd_d        = '0;
        ex_regdata1_d  = '0;
        ex_regdata2_d  = '0;
        ex_imm_d       = '0;
        ex_ctrl_d      = '0;
        ex_mem_read_d  = 1'b0;
        ex_reg_write_d = 1'b0;
        if (!bubble) begin
            ex_valid_d     = id_valid_i;
            ex_rs_d        = id_rs_i;
            ex_rt_d        = id_rt_i;
            ex_rd_d        = id_rd_i;
            ex_regdata1_d  = rdata1;
            ex_regdata2_d  = rdata2;
            ex_imm_d       = id_imm_i;
            ex_ctrl_d      = id_ctrl_i;
            ex_mem_read_d  = id_valid_i && id_mem_read_i;
            ex_reg_write_d = id_valid_i && id_reg_write_i;
        end
    end

    assign stall_cnt_d = (stall_o && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_regdata1_q  <= '0;
            ex_regdata2_q  <= '0;
            ex_imm_q       <= '0;
            ex_ctrl_q      <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd_q        <= ex_rd_d;
            ex_regdata1_q  <= ex_regdata1_d;
            ex_regdata2_q  <= ex_regdata2_d;
            ex_imm_q       <= ex_imm_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // EX/MEM is the younger producer, so it takes priority over MEM/WB.
    always_comb begin
        forwardA_o = !ex_valid_q ? 2'b00 :
                     (ex_mem_reg_write_i && ex_mem_rd_i != 5'd0 && ex_mem_rd_i == ex_rs_q) ? 2'b01 :
                     (mem_wb_reg_write_i && mem_wb_rd_i != 5'd0 && mem_wb_rd_i == ex_rs_q) ? 2'b10 : 2'b00;
        forwardB_o = !ex_valid_q ? 2'b00 :
                     (ex_mem_reg_write_i && ex_mem_rd_i != 5'd0 && ex_mem_rd_i == ex_rt_q) ? 2'b01 :
                     (mem_wb_reg_write_i && mem_wb_rd_i != 5'd0 && mem_wb_rd_i == ex_rt_q) ? 2'b10 : 2'b00;
    end

    assign ex_valid_o     = ex_valid_q;
    assign ex_rs_o        = ex_rs_q;
    assign ex_rt_o        = ex_rt_q;
    assign ex_rd_o        = ex_rd_q;
    assign ex_regdata1_o  = ex_regdata1_q;
    assign ex_regdata2_o  = ex_regdata2_q;
    assign ex_imm_o       = ex_imm_q;
    assign ex_ctrl_o      = ex_ctrl_q;
    assign ex_mem_read_o  = ex_mem_read_q;
    assign ex_reg_write_o = ex_reg_write_q;
    assign stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a slot-level reference model.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int CW = 12;
    localparam int NW = 4;

    typedef struct packed {
        logic          v;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] d1, d2, imm;
        logic [CW-1:0] ctrl;
        logic          mr, rw;
    } ex_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic id_valid, id_mem_read, id_reg_write, flush;
    logic [4:0] id_rs, id_rt, id_rd, em_rd, mw_rd;
    logic [DW-1:0] id_d1, id_d2, id_imm, mw_wdata;
    logic [CW-1:0] id_ctrl;
    logic em_w, mw_w;
    logic stall, ex_valid, ex_mr, ex_rw;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_d1, ex_d2, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [1:0] fa, fb;
    logic [NW-1:0] cnt;

    ex_t m;
    logic [NW-1:0] mcnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rd_i(id_rd), .id_regdata1_i(id_d1), .id_regdata2_i(id_d2), .id_imm_i(id_imm),
        .id_ctrl_i(id_ctrl), .id_mem_read_i(id_mem_read), .id_reg_write_i(id_reg_write),
        .flush_i(flush), .ex_mem_reg_write_i(em_w), .ex_mem_rd_i(em_rd),
        .mem_wb_reg_write_i(mw_w), .mem_wb_rd_i(mw_rd), .mem_wb_wdata_i(mw_wdata),
        .stall_o(stall), .ex_valid_o(ex_valid), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
        .ex_regdata1_o(ex_d1), .ex_regdata2_o(ex_d2), .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl),
        .ex_mem_read_o(ex_mr), .ex_reg_write_o(ex_rw), .forwardA_o(fa), .forwardB_o(fb),
        .stall_cnt_o(cnt)
    );

    function automatic ex_t dut_slot();
        return '{ex_valid, ex_rs, ex_rt, ex_rd, ex_d1, ex_d2, ex_imm, ex_ctrl, ex_mr, ex_rw};
    endfunction

    function automatic logic m_hazard();
        return m.v && m.mr && m.rw && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (!m.v) return 2'b00;
        if (em_w && em_rd != 0 && em_rd == r) return 2'b01;
        if (mw_w && mw_rd != 0 && mw_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, rt, rd, input logic mr, rw, fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_mem_read = mr; id_reg_write = rw; flush = fl;
        id_d1 = $urandom; id_d2 = $urandom; id_imm = $urandom; id_ctrl = CW'($urandom);
    endtask

    task automatic bypass(input logic ew, input logic [4:0] erd, input logic ww, input logic [4:0] wrd);
        em_w = ew; em_rd = erd; mw_w = ww; mw_rd = wrd; mw_wdata = $urandom;
    endtask

    // Advance one clock; the model takes the slot the specification says the edge produces.
    task automatic step();
        ex_t nm;
        logic hz;
        hz = m_hazard();
        nm = '0;
        if (!(flush || hz)) begin
            nm = '{id_valid, id_rs, id_rt, id_rd, id_d1, id_d2, id_imm, id_ctrl,
                   id_valid & id_mem_read, id_valid & id_reg_write};
`ifdef WB_BYPASS_EN
            if (mw_w && mw_rd != 0 && mw_rd == id_rs) nm.d1 = mw_wdata;
            if (mw_w && mw_rd != 0 && mw_rd == id_rt) nm.d2 = mw_wdata;
`endif
        end
        @(posedge clk);
        if (hz && !flush && mcnt != {NW{1'b1}}) mcnt = mcnt + 1'b1;
        m = nm;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        bypass(0, 0, 0, 0);
        rst_n = 1'b0;
        m = '0; mcnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 1, 2, 8, 1, 1, 0); step();
        drive(1, 8, 3, 9, 0, 1, 0);
        bypass(1, 1, 1, 2);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL reset_pre_stall got %b want 1", stall); end
        rst_n = 1'b0; m = '0; mcnt = '0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++;
        if (dut_slot() !== ex_t'(0)) begin errors++; $display("FAIL reset_slot got %h want 0", dut_slot()); end
        checks++;
        if (cnt !== '0 || fa !== 2'b00 || fb !== 2'b00)
            begin errors++; $display("FAIL reset_cnt_fwd got %h/%b/%b want 0/00/00", cnt, fa, fb); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 1, 2, 8, 1, 1, 0); step();
        drive(1, 8, 3, 9, 0, 1, 0); #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_rw !== 1'b0 || ex_mr !== 1'b0 || ex_ctrl !== '0)
            begin errors++; $display("FAIL lu_bubble got v%b w%b r%b c%h want 0", ex_valid, ex_rw, ex_mr, ex_ctrl); end
        checks++;
        if (stall !== 1'b0 || cnt !== 4'd1) begin errors++; $display("FAIL lu_after got %b/%0d want 0/1", stall, cnt); end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_rd !== 5'd9 || ex_rw !== 1'b1)
            begin errors++; $display("FAIL lu_enter got v%b rs%0d rd%0d w%b want 1/8/9/1", ex_valid, ex_rs, ex_rd, ex_rw); end
    endtask

    task automatic test_forward_priority();
        do_reset();
        drive(1, 5, 5, 6, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        bypass(1, 5, 1, 5); #1;
        checks++;
        if (fa !== 2'b01 || fb !== 2'b01) begin errors++; $display("FAIL fwd_exmem got %b/%b want 01/01", fa, fb); end
        em_w = 1'b0; #1;
        checks++;
        if (fa !== 2'b10 || fb !== 2'b10) begin errors++; $display("FAIL fwd_memwb got %b/%b want 10/10", fa, fb); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 0, 0, 4, 0, 1, 0); step();
        bypass(1, 0, 1, 0); #1;
        checks++;
        if (fa !== 2'b00 || fb !== 2'b00) begin errors++; $display("FAIL zero_fwd got %b/%b want 00/00", fa, fb); end
        bypass(0, 0, 0, 0);
        drive(1, 1, 2, 0, 1, 1, 0); step();
        drive(1, 0, 0, 7, 0, 1, 0); #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", stall); end
    endtask

    task automatic test_flush_vs_hazard();
        do_reset();
        drive(1, 1, 2, 8, 1, 1, 0); step();
        drive(1, 3, 8, 9, 0, 1, 1); #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_rw !== 1'b0 || cnt !== 4'd0)
            begin errors++; $display("FAIL flush_bubble got v%b w%b cnt%0d want 0/0/0", ex_valid, ex_rw, cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 2, 8, 1, 1, 0); step();
            drive(1, 8, 8, 9, 0, 1, 0); step();
        end
        checks++;
        if (cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt got %h want f", cnt); end
        drive(1, 1, 2, 8, 1, 1, 0); step();
        drive(1, 8, 2, 9, 0, 1, 0); step();
        checks++;
        if (cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %h want f", cnt); end
    endtask

    task automatic test_bypass();
        do_reset();
        bypass(0, 0, 1, 3);
        mw_wdata = 32'hDEADBEEF;
        drive(1, 3, 4, 5, 0, 1, 0);
        id_d1 = '0;
        step();
        checks++;
`ifdef WB_BYPASS_EN
        if (ex_d1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_d1 got %h want deadbeef", ex_d1); end
`else
        if (ex_d1 !== 32'h0) begin errors++; $display("FAIL bypass_d1 got %h want 0", ex_d1); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0);
            bypass($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
            #1;
            checks++;
            if (stall !== (m_hazard() && !flush)) begin errors++; $display("FAIL rnd_stall[%0d] got %b", i, stall); end
            checks++;
            if (fa !== m_fwd(m.rs) || fb !== m_fwd(m.rt))
                begin errors++; $display("FAIL rnd_fwd[%0d] got %b/%b want %b/%b", i, fa, fb, m_fwd(m.rs), m_fwd(m.rt)); end
            step();
            checks++;
            if (dut_slot() !== m) begin errors++; $display("FAIL rnd_slot[%0d] got %h want %h", i, dut_slot(), m); end
            checks++;
            if (cnt !== mcnt) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, cnt, mcnt); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward_priority();
        test_zero_reg();
        test_flush_vs_hazard();
        test_saturation();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
